// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator core: opcodes, FSM states and
// latency helpers (edges from the accepting edge to the edge raising done).
package calc_pkg;

    typedef enum logic [2:0] {
        OP_INV0 = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_DIV  = 3'b100,
        OP_SQRT = 3'b101,
        OP_GCD  = 3'b110,
        OP_INV7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int lat_mul(input int dw);
        return dw + 2;
    endfunction

    function automatic int lat_div(input int dw);
        return dw + 2;
    endfunction

    function automatic int lat_sqrt(input int dw);
        return dw / 2 + 2;
    endfunction

endpackage

// File: rtl/calc_seq_engine_if.sv
// Request/response bundle between the calculator pin logic (master) and the engine (slave).
// The err signal exists only when CALC_ERR_EN is defined.
interface calc_seq_engine_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    start;
    logic [2:0]              op;
    logic [DATA_WIDTH-1:0]   opa;
    logic [DATA_WIDTH-1:0]   opb;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    ready;
    logic                    done;
`ifdef CALC_ERR_EN
    logic                    err;

    modport master (output start, op, opa, opb, input result, ready, done, err);
    modport slave  (input start, op, opa, opb, output result, ready, done, err);
`else
    modport master (output start, op, opa, opb, input result, ready, done);
    modport slave  (input start, op, opa, opb, output result, ready, done);
`endif
endinterface

// File: rtl/calc_gcd_bin.sv
// Binary (Stein) GCD, one reduction step per clock. done_o is combinational and
// marks the cycle in which result_o is valid; the unit drops busy on that edge.
module calc_gcd_bin #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] result_o
);
    localparam int KW = $clog2(DW) + 1;

    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0] k_q, k_d;
    logic          busy_q, busy_d;

    assign busy_o   = busy_q;
    assign done_o   = busy_q && ((a_q == '0) || (b_q == '0));
    // The remaining non-zero operand carries the odd part; k restores common twos.
    assign result_o = (a_q | b_q) << k_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        busy_d = busy_q;
        if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            k_d    = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
            end else if (!a_q[0] && !b_q[0]) begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                k_d = k_q + KW'(1);
            end else if (!a_q[0]) begin
                a_d = a_q >> 1;
            end else if (!b_q[0]) begin
                b_d = b_q >> 1;
            end else if (a_q >= b_q) begin
                a_d = (a_q - b_q) >> 1;
            end else begin
                b_d = (b_q - a_q) >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/calc_seq_engine.sv
// Iterative calculator core: add/sub/mul/div/sqrt share one shift datapath, gcd runs
// in calc_gcd_bin. Define CALC_ERR_EN to get the err flag (invalid op, divide by zero).
module calc_seq_engine
    import calc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    calc_seq_engine_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH + 2) + 1;

    state_e          state_q, state_d;
    op_e             op_q, op_d, op_in;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DW-1:0] acc_q, acc_d, result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept, finish;
    logic [2*DW-1:0] fin_result;
    logic            gcd_start, gcd_busy, gcd_done;
    logic [DW-1:0]   gcd_result;

    assign op_in     = op_e'(bus.op);
    assign accept    = bus.start && (state_q != EXEC);
    assign gcd_start = accept && (op_in == OP_GCD);

    calc_gcd_bin #(.DW(DW)) u_gcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (gcd_start),
        .a_i      (bus.opa),
        .b_i      (bus.opb),
        .busy_o   (gcd_busy),
        .done_o   (gcd_done),
        .result_o (gcd_result)
    );

    logic [DW:0]     mul_sum, div_sh, div_diff, add_sum, sub_diff;
    logic [DW-1:0]   sq_rsh, sq_r, sq_sub, sq_add;
    logic [HW-1:0]   sq_q;
    logic [2*DW-1:0] mul_next, div_next, sq_next;

    // mul: acc = {partial, multiplier}, add multiplicand on lsb then shift right.
    assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[DW-1:1]};
    // div: acc = {remainder, quotient}; a zero divisor naturally yields all-ones / opa.
    assign div_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_next = div_diff[DW] ? {div_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                                   : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
    // sqrt: a_q feeds radicand pairs, b_q holds the signed partial remainder, acc low holds root.
    assign sq_q     = acc_q[HW-1:0];
    assign sq_rsh   = {b_q[DW-3:0], a_q[DW-1:DW-2]};
    assign sq_sub   = DW'({sq_q, 2'b01});
    assign sq_add   = DW'({sq_q, 2'b11});
    assign sq_r     = b_q[DW-1] ? (sq_rsh + sq_add) : (sq_rsh - sq_sub);
    assign sq_next  = {acc_q[2*DW-1:HW], sq_q[HW-2:0], ~sq_r[DW-1]};

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        fin_result = '0;
        case (op_q)
            OP_ADD:                  fin_result = {{(DW-1){1'b0}}, add_sum};
            OP_SUB:                  fin_result = {{(DW-1){sub_diff[DW]}}, sub_diff};
            OP_MUL, OP_DIV, OP_SQRT: fin_result = acc_q;
            OP_GCD:                  fin_result = {{DW{1'b0}}, gcd_result};
            default:                 ;
        endcase
    end

    assign finish = (state_q == EXEC) &&
                    ((op_q == OP_GCD) ? (gcd_busy && gcd_done) : (cnt_q == '0));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            EXEC: begin
                if (finish) begin
                    state_d  = DONE;
                    result_d = fin_result;
                end else if (op_q != OP_GCD) begin
                    cnt_d = cnt_q - CW'(1);
                    // The last counted cycle is idle so every op ends one edge after its final step.
                    if (cnt_q >= CW'(2)) begin
                        case (op_q)
                            OP_MUL:  acc_d = mul_next;
                            OP_DIV:  acc_d = div_next;
                            OP_SQRT: begin
                                acc_d = sq_next;
                                b_d   = sq_r;
                                a_d   = a_q << 2;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                if (accept) begin
                    state_d = EXEC;
                    op_d    = op_in;
                    a_d     = bus.opa;
                    b_d     = (op_in == OP_SQRT) ? '0 : bus.opb;
                    acc_d   = (op_in == OP_MUL || op_in == OP_DIV) ? {{DW{1'b0}}, bus.opa} : '0;
                    case (op_in)
                        OP_MUL:  cnt_d = CW'(lat_mul(DW) - 1);
                        OP_DIV:  cnt_d = CW'(lat_div(DW) - 1);
                        OP_SQRT: cnt_d = CW'(lat_sqrt(DW) - 1);
                        default: cnt_d = CW'(1);
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_INV0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = (state_q != EXEC);
    assign bus.done   = (state_q == DONE);

`ifdef CALC_ERR_EN
    logic err_q, fin_err;

    assign fin_err = (op_q == OP_INV0) || (op_q == OP_INV7) || ((op_q == OP_DIV) && (b_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (finish) begin
            err_q <= fin_err;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed bench for calc_seq_engine at DATA_WIDTH=16; err checks only when CALC_ERR_EN is defined.
module tb_calc_seq_engine;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    calc_seq_engine_if #(.DATA_WIDTH(16)) bus ();

    calc_seq_engine #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check_eq("issue ready timeout", {63'd0, bus.ready}, 64'd1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output logic [31:0] res, output logic err, output int lat);
        lat = lat0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 100);
        if (!bus.done) check_eq("done timeout", {63'd0, bus.done}, 64'd1);
        res = bus.result;
`ifdef CALC_ERR_EN
        err = bus.err;
`else
        err = 1'b0;
`endif
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input logic exp_err);
        logic [31:0] res;
        logic        err;
        int          lat;
        issue(op, a, b);
        wait_done(0, res, err, lat);
        check_eq({tag, " result"}, res, exp_res);
        if (exp_lat >= 0) check_eq({tag, " latency"}, lat, exp_lat);
        else              check_eq({tag, " latency<=35"}, {63'd0, lat <= 35}, 64'd1);
`ifdef CALC_ERR_EN
        check_eq({tag, " err"}, {63'd0, err}, {63'd0, exp_err});
`else
        if (err || exp_err) begin end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic        err;
        int          lat;
        int          n_done;

        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset ready", {63'd0, bus.ready}, 64'd1);
        check_eq("reset done", {63'd0, bus.done}, 64'd0);
        check_eq("reset result", bus.result, 64'd0);
        rst_n = 1'b1;

        run("add ffff+1", OP_ADD, 16'hFFFF, 16'h0001, 32'h0001_0000, 2, 1'b0);
        run("sub 3-5", OP_SUB, 16'd3, 16'd5, 32'hFFFF_FFFE, 2, 1'b0);
        run("mul ffff*ffff", OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 18, 1'b0);
        run("div 100/7", OP_DIV, 16'd100, 16'd7, {16'd2, 16'd14}, 18, 1'b0);
        run("div 5/0", OP_DIV, 16'd5, 16'd0, {16'd5, 16'hFFFF}, 18, 1'b1);
        run("op 111", 3'b111, 16'h1234, 16'h5678, 32'h0, 2, 1'b1);
        run("op 000", 3'b000, 16'h00AA, 16'h0055, 32'h0, 2, 1'b1);
        run("sqrt ffff", OP_SQRT, 16'hFFFF, 16'h0000, 32'h0000_00FF, 10, 1'b0);
        run("sqrt 0", OP_SQRT, 16'h0000, 16'h1234, 32'h0, 10, 1'b0);
        run("sqrt 99", OP_SQRT, 16'd99, 16'hFFFF, 32'd9, 10, 1'b0);
        run("gcd 48,18", OP_GCD, 16'd48, 16'd18, 32'd6, -1, 1'b0);
        run("gcd 0,0", OP_GCD, 16'd0, 16'd0, 32'd0, -1, 1'b0);
        run("gcd 8000,0", OP_GCD, 16'h8000, 16'd0, 32'h0000_8000, -1, 1'b0);
        run("gcd 0,21", OP_GCD, 16'd0, 16'd21, 32'd21, -1, 1'b0);

        // start pulsed while a mul is busy must be dropped
        issue(OP_MUL, 16'd3, 16'd5);
        repeat (3) @(posedge clk);
        #1;
        check_eq("busy ready", {63'd0, bus.ready}, 64'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.opa   = 16'd1;
        bus.opb   = 16'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(4, res, err, lat);
        check_eq("busy mul result", res, 32'd15);
        check_eq("busy mul latency", lat, 18);
        n_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check_eq("busy extra done", n_done, 0);
        check_eq("busy result held", bus.result, 32'd15);

        // asynchronous reset in the middle of a divide
        issue(OP_DIV, 16'd1000, 16'd3);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst ready", {63'd0, bus.ready}, 64'd1);
        check_eq("midrst done", {63'd0, bus.done}, 64'd0);
        check_eq("midrst result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check_eq("midrst stale done", n_done, 0);

        // back-to-back: second add issued during the DONE cycle of the first
        run("add 1+2", OP_ADD, 16'd1, 16'd2, 32'd3, 2, 1'b0);
        issue(OP_ADD, 16'd10, 16'd20);
        check_eq("b2b ready", {63'd0, bus.ready}, 64'd0);
        check_eq("b2b done low", {63'd0, bus.done}, 64'd0);
        check_eq("b2b result held", bus.result, 32'd3);
        wait_done(0, res, err, lat);
        check_eq("b2b result", res, 32'd30);
        check_eq("b2b latency", lat, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
